// File: rtl/obi_scratch_responder.sv
`default_nettype none
// ============================================================================
//  Module   : obi_scratch_responder
//  Brief    : OBI responder serving a word-addressed scratchpad. Same-cycle
//             grant, access at grant, fixed-latency rvalid/rdata, bounded
//             number of outstanding transactions.
//  Options  : OBI_RESP_ADDR_CHECK_EN - out-of-range accesses are answered
//             with 32'hBADC_AB1E (reads) / dropped (writes) and raise the
//             sticky addr_err_o flag. Undefined: addresses alias modulo
//             NUM_WORDS and addr_err_o is tied low.
//  Revision : 1.0 - initial release
// ============================================================================

package obi_scratch_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_scratch_responder
    import obi_scratch_pkg::*;
#(
    parameter int unsigned NUM_WORDS       = 256,
    parameter int unsigned LATENCY         = 1,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic        clk_gen,
    input  logic        rst_n,
    input  obi_req_t    req_i,
    output obi_resp_t   resp_o,
    output logic        busy_o,
    output logic [15:0] txn_count_o,
    output logic        addr_err_o
);
    localparam int unsigned c_IDX_W    = $clog2(NUM_WORDS);
    localparam int unsigned c_CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] c_BAD_DATA = 32'hBADC_AB1E;

    logic [31:0]        r_mem [NUM_WORDS];
    logic [LATENCY-1:0] r_pv;
    logic [31:0]        r_pd [LATENCY];
    logic [c_CNT_W-1:0] r_out;
    logic [15:0]        r_txn;

    logic [31:0]        w_offset;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_in_range;
    logic               w_retire;
    logic               w_gnt;
    logic               w_wr_en;
    logic [31:0]        w_load_data;
    logic               w_unused;

    assign w_offset = req_i.addr - BASE_ADDR;
    assign w_idx    = w_offset[c_IDX_W+1:2];
    assign w_retire = r_pv[LATENCY-1];

`ifdef OBI_RESP_ADDR_CHECK_EN
    // Unsigned offset compare also catches addresses below BASE_ADDR (wrap).
    assign w_in_range = (w_offset < 32'(NUM_WORDS * 4));
    assign w_unused   = ^w_offset[1:0];
`else
    assign w_in_range = 1'b1;
    assign w_unused   = ^{w_offset[31:c_IDX_W+2], w_offset[1:0]};
`endif

    // A slot freed by this cycle's rvalid may be re-granted in the same cycle.
    assign w_gnt = rst_n & req_i.req &
                   ((r_out < c_CNT_W'(MAX_OUTSTANDING)) | w_retire);

    assign w_wr_en     = w_gnt & req_i.we & w_in_range;
    assign w_load_data = req_i.we   ? 32'h0 :
                         w_in_range ? r_mem[w_idx] : c_BAD_DATA;

    // Byte-lane writes at the grant edge; contents intentionally not reset.
    always_ff @(posedge clk_gen) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (req_i.be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= req_i.wdata[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 captured at grant, last stage is the response.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_pd[i] <= 32'h0;
            end
        end else begin
            r_pv[0] <= w_gnt;
            r_pd[0] <= w_gnt ? w_load_data : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    // Outstanding count: grant adds, rvalid retires, both together cancel.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else if (w_gnt && !w_retire) begin
            r_out <= r_out + c_CNT_W'(1);
        end else if (!w_gnt && w_retire) begin
            r_out <= r_out - c_CNT_W'(1);
        end
    end

    // Saturating count of granted transactions.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_txn <= 16'h0;
        end else if (w_gnt && (r_txn != 16'hFFFF)) begin
            r_txn <= r_txn + 16'd1;
        end
    end

`ifdef OBI_RESP_ADDR_CHECK_EN
    logic r_err;

    // Sticky flag raised by any granted out-of-range access.
    always_ff @(posedge clk_gen or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_gnt && !w_in_range) begin
            r_err <= 1'b1;
        end
    end

    assign addr_err_o = r_err;
`else
    assign addr_err_o = 1'b0;
`endif

    assign resp_o      = '{gnt: w_gnt, rvalid: r_pv[LATENCY-1], rdata: r_pd[LATENCY-1]};
    assign busy_o      = (r_out != '0);
    assign txn_count_o = r_txn;

endmodule
`default_nettype wire

// File: tb/tb_obi_scratch_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obi_scratch_responder
//  Brief    : Self-checking bench for obi_scratch_responder (LATENCY=3,
//             MAX_OUTSTANDING=2, 16 words) against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_obi_scratch_responder;
    import obi_scratch_pkg::*;

    localparam int unsigned c_L    = 3;
    localparam int unsigned c_M    = 2;
    localparam int unsigned c_NW   = 16;
    localparam logic [31:0] c_BASE = 32'h0000_1000;
`ifdef OBI_RESP_ADDR_CHECK_EN
    localparam bit c_CHK = 1'b1;
`else
    localparam bit c_CHK = 1'b0;
`endif

    logic        clk_gen = 1'b0;
    logic        rst_n   = 1'b0;
    obi_req_t    rq;
    obi_resp_t   resp_o;
    logic        busy_o;
    logic [15:0] txn_count_o;
    logic        addr_err_o;

    obi_scratch_responder #(
        .NUM_WORDS      (c_NW),
        .LATENCY        (c_L),
        .MAX_OUTSTANDING(c_M),
        .BASE_ADDR      (c_BASE)
    ) dut (
        .clk_gen    (clk_gen),
        .rst_n      (rst_n),
        .req_i      (rq),
        .resp_o     (resp_o),
        .busy_o     (busy_o),
        .txn_count_o(txn_count_o),
        .addr_err_o (addr_err_o)
    );

    always #5 clk_gen = ~clk_gen;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [31:0] data;
    } pend_t;

    pend_t       pq[$];
    logic [31:0] m_mem [c_NW];
    logic [15:0] m_txn = 16'h0;
    logic        m_err = 1'b0;

    function automatic int midx(input logic [31:0] a);
        logic [31:0] off;
        off = a - c_BASE;
        return int'((off >> 2) % c_NW);
    endfunction

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= c_BASE) && (a < c_BASE + c_NW * 4);
    endfunction

    // Compare process: every cycle, DUT outputs against the model.
    initial begin
        bit          ret, eg, ok;
        logic [31:0] d;
        forever begin
            @(negedge clk_gen);
            cyc++;
            if (!rst_n) begin
                chk("rst_gnt",    32'(resp_o.gnt),    32'h0);
                chk("rst_rvalid", 32'(resp_o.rvalid), 32'h0);
                chk("rst_rdata",  resp_o.rdata,       32'h0);
                chk("rst_busy",   32'(busy_o),        32'h0);
                chk("rst_txn",    32'(txn_count_o),   32'h0);
                chk("rst_err",    32'(addr_err_o),    32'h0);
                pq.delete();
                m_txn = 16'h0;
                m_err = 1'b0;
            end else begin
                ret = (pq.size() > 0) && (pq[0].due == cyc);
                eg  = rq.req && ((pq.size() < c_M) || ret);
                chk("gnt",    32'(resp_o.gnt),    32'(eg));
                chk("rvalid", 32'(resp_o.rvalid), 32'(ret));
                chk("rdata",  resp_o.rdata,       ret ? pq[0].data : 32'h0);
                chk("busy",   32'(busy_o),        32'(pq.size() != 0));
                chk("txn",    32'(txn_count_o),   32'(m_txn));
                chk("err",    32'(addr_err_o),    32'(m_err));
                if (ret) void'(pq.pop_front());
                if (eg) begin
                    ok = !c_CHK || in_rng(rq.addr);
                    if (rq.we) begin
                        d = 32'h0;
                        if (ok) begin
                            for (int b = 0; b < 4; b++)
                                if (rq.be[b]) m_mem[midx(rq.addr)][8*b +: 8] = rq.wdata[8*b +: 8];
                        end
                    end else begin
                        d = ok ? m_mem[midx(rq.addr)] : 32'hBADC_AB1E;
                    end
                    pq.push_back('{due: cyc + c_L, data: d});
                    if (m_txn != 16'hFFFF) m_txn = m_txn + 16'd1;
                    if (!ok) m_err = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after the grant
    // with the request still asserted (caller decides what comes next).
    task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, output time gt);
        int guard;
        guard = 0;
        gt    = 0;
        rq.req = 1'b1; rq.we = we; rq.be = be; rq.addr = addr; rq.wdata = wd;
        forever begin
            @(negedge clk_gen);
            if (resp_o.gnt) begin
                gt = $time;
                break;
            end
            guard++;
            if (guard > 40) begin
                n_total++;
                $display("FAIL gnt_timeout: no grant after %0d cycles, expected grant", guard);
                break;
            end
            @(posedge clk_gen); #1;
        end
        @(posedge clk_gen); #1;
    endtask

    task automatic expect_resp(input string name, input logic [31:0] exp);
        rq.req = 1'b0;
        repeat (c_L) @(negedge clk_gen);
        chk({name, "_rvalid"}, 32'(resp_o.rvalid), 32'h1);
        chk({name, "_rdata"},  resp_o.rdata, exp);
        @(posedge clk_gen); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        time g[4];
        time gt;
        bit  pend;

        rq = '0;
        rq.req  = 1'b1;
        rq.addr = c_BASE;
        repeat (3) @(posedge clk_gen);
        #1;
        rst_n = 1'b1;

        // Known contents everywhere.
        for (int i = 0; i < c_NW; i++)
            txn(1'b1, 4'hF, c_BASE + 32'(i * 4), 32'h5A5A_0000 + 32'(i), gt);
        rq.req = 1'b0;
        @(negedge clk_gen);
        chk("txn_after_init", 32'(txn_count_o), 32'd16);
        @(posedge clk_gen); #1;

        // Write then read back.
        txn(1'b1, 4'hF, c_BASE + 32'h10, 32'hDEAD_BEEF, gt);
        txn(1'b0, 4'hF, c_BASE + 32'h10, 32'h0, gt);
        expect_resp("raw_deadbeef", 32'hDEAD_BEEF);

        // Byte enables.
        txn(1'b1, 4'hF,    c_BASE + 32'h20, 32'h1122_3344, gt);
        txn(1'b1, 4'b0101, c_BASE + 32'h20, 32'hAABB_CCDD, gt);
        txn(1'b0, 4'h0,    c_BASE + 32'h20, 32'h0, gt);
        expect_resp("byte_en", 32'h11BB_33DD);

        // Throttling: two grants, stall, then re-grant on each retiring cycle.
        for (int i = 0; i < 4; i++) txn(1'b0, 4'hF, c_BASE, 32'h0, g[i]);
        rq.req = 1'b0;
        chk("thr_gap1", 32'((g[1] - g[0]) / 10), 32'd1);
        chk("thr_gap2", 32'((g[2] - g[0]) / 10), 32'd3);
        chk("thr_gap3", 32'((g[3] - g[0]) / 10), 32'd4);
        repeat (c_L + 1) @(posedge clk_gen);
        #1;

        // One word past the end.
        txn(1'b0, 4'hF, c_BASE + 32'(c_NW * 4), 32'h0, gt);
        expect_resp("oor_read", c_CHK ? 32'hBADC_AB1E : 32'h5A5A_0000);
        @(negedge clk_gen);
        chk("oor_err", 32'(addr_err_o), 32'(c_CHK));
        @(posedge clk_gen); #1;

        // Reset one cycle after granting a read.
        txn(1'b0, 4'hF, c_BASE + 32'h4, 32'h0, gt);
        rq.req = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk_gen); #1;
        rst_n = 1'b1;
        for (int i = 0; i < c_L + 1; i++) begin
            @(negedge clk_gen);
            chk("post_rst_rvalid", 32'(resp_o.rvalid), 32'h0);
        end
        chk("post_rst_busy", 32'(busy_o), 32'h0);
        chk("post_rst_txn",  32'(txn_count_o), 32'h0);
        chk("post_rst_err",  32'(addr_err_o), 32'h0);
        @(posedge clk_gen); #1;
        txn(1'b0, 4'hF, c_BASE + 32'h4, 32'h0, gt);
        expect_resp("post_rst_read", 32'h5A5A_0001);
        @(negedge clk_gen);
        chk("post_rst_txn1", 32'(txn_count_o), 32'h1);
        @(posedge clk_gen); #1;

        // Random traffic; a refused request is held unchanged.
        pend = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (!pend) begin
                rq.req   = ($urandom_range(0, 3) != 0);
                rq.we    = 1'($urandom_range(0, 1));
                rq.be    = 4'($urandom);
                rq.wdata = $urandom;
                if ($urandom_range(0, 9) == 0) rq.addr = $urandom;
                else rq.addr = c_BASE + 32'($urandom_range(0, c_NW - 1) * 4) + 32'($urandom_range(0, 3));
            end
            @(negedge clk_gen);
            pend = rq.req && !resp_o.gnt;
            @(posedge clk_gen); #1;
        end
        rq.req = 1'b0;
        repeat (c_L + 2) @(posedge clk_gen);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
